// File: rtl/lb_arbiter.sv
// Round-robin arbiter sharing one CSR slave port between two local-bus masters, one whole transaction at a time.
// Grant registered: slave sees the request 1 cycle later; slave stalls via s_wready, missing s_rvalid ends in a timeout response.
module lb_arbiter #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 16,
   parameter int STRB_W  = DATA_W/8,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,

   input  logic [ADDR_W-1:0] m0_waddr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [STRB_W-1:0] m0_wstrb,
   input  logic              m0_wen,
   output logic              m0_wready,
   input  logic [ADDR_W-1:0] m0_raddr,
   input  logic              m0_ren,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_rvalid,

   input  logic [ADDR_W-1:0] m1_waddr,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic [STRB_W-1:0] m1_wstrb,
   input  logic              m1_wen,
   output logic              m1_wready,
   input  logic [ADDR_W-1:0] m1_raddr,
   input  logic              m1_ren,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_rvalid,

   output logic [ADDR_W-1:0] s_waddr,
   output logic [DATA_W-1:0] s_wdata,
   output logic [STRB_W-1:0] s_wstrb,
   output logic              s_wen,
   input  logic              s_wready,
   output logic [ADDR_W-1:0] s_raddr,
   output logic              s_ren,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic              s_rvalid,

   output logic [1:0]        gnt,
   output logic              timeout_err
);

   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WR       = 2'd1,
      RD_ISSUE = 2'd2,
      RD_WAIT  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        gnt_q, gnt_d;
   logic              last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] raddr_q, raddr_d;

   logic              req0, req1;
   logic              pick1;
   logic              sel;
   logic              g_wen;
   logic              done;
   logic [1:0]        wready_c;
   logic [1:0]        rvalid_c;
   logic [DATA_W-1:0] rdata_c;

   assign req0  = m0_wen | m0_ren;
   assign req1  = m1_wen | m1_ren;
   // On a tie m1 wins only if m0 owned the previous completed transaction.
   assign pick1 = req1 & (~req0 | ~last_q);
   assign sel   = gnt_q[1];
   assign g_wen = sel ? m1_wen : m0_wen;

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      raddr_d     = raddr_q;
      s_waddr     = '0;
      s_wdata     = '0;
      s_wstrb     = '0;
      s_wen       = 1'b0;
      s_raddr     = '0;
      s_ren       = 1'b0;
      wready_c    = 2'b00;
      rvalid_c    = 2'b00;
      rdata_c     = '0;
      timeout_err = 1'b0;
      done        = 1'b0;

      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               gnt_d   = pick1 ? 2'b10 : 2'b01;
               raddr_d = pick1 ? m1_raddr : m0_raddr;
               state_d = (pick1 ? m1_wen : m0_wen) ? WR : RD_ISSUE;
            end
         end
         WR: begin
            if (!g_wen) begin
               state_d = IDLE;
               gnt_d   = 2'b00;
            end else begin
               s_wen   = 1'b1;
               s_waddr = sel ? m1_waddr : m0_waddr;
               s_wdata = sel ? m1_wdata : m0_wdata;
               s_wstrb = sel ? m1_wstrb : m0_wstrb;
               if (s_wready) begin
                  wready_c = gnt_q;
                  done     = 1'b1;
               end
            end
         end
         RD_ISSUE: begin
            s_ren   = 1'b1;
            s_raddr = raddr_q;
            cnt_d   = '0;
            state_d = RD_WAIT;
         end
         RD_WAIT: begin
            s_raddr = raddr_q;
            cnt_d   = cnt_q + CNT_W'(1);
            if (s_rvalid) begin
               rvalid_c = gnt_q;
               rdata_c  = s_rdata;
               done     = 1'b1;
            end else if (cnt_q == CNT_W'(TIMEOUT)) begin
               rvalid_c    = gnt_q;
               timeout_err = 1'b1;
               done        = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (done) begin
         last_d  = sel;
         state_d = IDLE;
         gnt_d   = 2'b00;
      end

      // Synchronous reset also squashes any response pulse in the reset cycle.
      if (rst) begin
         state_d     = IDLE;
         gnt_d       = 2'b00;
         last_d      = 1'b1;
         cnt_d       = '0;
         raddr_d     = '0;
         s_waddr     = '0;
         s_wdata     = '0;
         s_wstrb     = '0;
         s_wen       = 1'b0;
         s_raddr     = '0;
         s_ren       = 1'b0;
         wready_c    = 2'b00;
         rvalid_c    = 2'b00;
         rdata_c     = '0;
         timeout_err = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      raddr_q <= raddr_d;
   end

   assign gnt       = gnt_q;
   assign m0_wready = wready_c[0];
   assign m1_wready = wready_c[1];
   assign m0_rvalid = rvalid_c[0];
   assign m1_rvalid = rvalid_c[1];
   assign m0_rdata  = rvalid_c[0] ? rdata_c : '0;
   assign m1_rdata  = rvalid_c[1] ? rdata_c : '0;

endmodule

// File: tb/tb_lb_arbiter.sv
// Directed bench for lb_arbiter: writes, reads, contention, timeout, abort and reset cases.
module tb_lb_arbiter;

   localparam int ADDR_W  = 8;
   localparam int DATA_W  = 16;
   localparam int STRB_W  = 2;
   localparam int TIMEOUT = 255;

   logic              clk;
   logic              rst;
   logic [ADDR_W-1:0] m0_waddr, m1_waddr, m0_raddr, m1_raddr;
   logic [DATA_W-1:0] m0_wdata, m1_wdata;
   logic [STRB_W-1:0] m0_wstrb, m1_wstrb;
   logic              m0_wen, m1_wen, m0_ren, m1_ren;
   logic              m0_wready, m1_wready, m0_rvalid, m1_rvalid;
   logic [DATA_W-1:0] m0_rdata, m1_rdata;
   logic [ADDR_W-1:0] s_waddr, s_raddr;
   logic [DATA_W-1:0] s_wdata, s_rdata;
   logic [STRB_W-1:0] s_wstrb;
   logic              s_wen, s_wready, s_ren, s_rvalid;
   logic [1:0]        gnt;
   logic              timeout_err;

   int tests = 0;
   int fails = 0;
   int early;
   int n0, n1;
   logic [1:0] exp_g;

   lb_arbiter #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .STRB_W (STRB_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .m0_waddr   (m0_waddr),
      .m0_wdata   (m0_wdata),
      .m0_wstrb   (m0_wstrb),
      .m0_wen     (m0_wen),
      .m0_wready  (m0_wready),
      .m0_raddr   (m0_raddr),
      .m0_ren     (m0_ren),
      .m0_rdata   (m0_rdata),
      .m0_rvalid  (m0_rvalid),
      .m1_waddr   (m1_waddr),
      .m1_wdata   (m1_wdata),
      .m1_wstrb   (m1_wstrb),
      .m1_wen     (m1_wen),
      .m1_wready  (m1_wready),
      .m1_raddr   (m1_raddr),
      .m1_ren     (m1_ren),
      .m1_rdata   (m1_rdata),
      .m1_rvalid  (m1_rvalid),
      .s_waddr    (s_waddr),
      .s_wdata    (s_wdata),
      .s_wstrb    (s_wstrb),
      .s_wen      (s_wen),
      .s_wready   (s_wready),
      .s_raddr    (s_raddr),
      .s_ren      (s_ren),
      .s_rdata    (s_rdata),
      .s_rvalid   (s_rvalid),
      .gnt        (gnt),
      .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive point just after the rising edge; sample point on the falling edge.
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      m0_waddr = '0; m0_wdata = '0; m0_wstrb = '0; m0_wen = 1'b0; m0_raddr = '0; m0_ren = 1'b0;
      m1_waddr = '0; m1_wdata = '0; m1_wstrb = '0; m1_wen = 1'b0; m1_raddr = '0; m1_ren = 1'b0;
      s_wready = 1'b0; s_rdata = '0; s_rvalid = 1'b0;

      repeat (2) @(posedge clk);
      smp();
      check("reset gnt", gnt, 2'b00);
      check("reset strobes", {s_wen, s_ren, m0_wready, m1_wready, m0_rvalid, m1_rvalid, timeout_err}, 7'b0);
      check("reset rdata", {m0_rdata, m1_rdata}, 32'h0);

      // Single write from m0
      nxt(); rst = 1'b0; m0_wen = 1'b1; m0_waddr = 8'h04; m0_wdata = 16'h0007; m0_wstrb = 2'b11; s_wready = 1'b1;
      smp();
      check("wr idle s_wen", s_wen, 1'b0);
      check("wr idle gnt", gnt, 2'b00);
      nxt(); smp();
      check("wr s_wen", s_wen, 1'b1);
      check("wr fields", {s_waddr, s_wdata, s_wstrb}, {8'h04, 16'h0007, 2'b11});
      check("wr m0_wready", m0_wready, 1'b1);
      check("wr m1_wready", m1_wready, 1'b0);
      check("wr gnt", gnt, 2'b01);
      nxt(); m0_wen = 1'b0; smp();
      check("wr done gnt", gnt, 2'b00);
      check("wr done strobes", {s_wen, m0_wready}, 2'b00);
      check("wr done s_waddr", s_waddr, 8'h00);

      // Single read from m1, slave answers 3 cycles after s_ren
      nxt(); m1_ren = 1'b1; m1_raddr = 8'h08; smp();
      check("rd idle s_ren", s_ren, 1'b0);
      nxt(); smp();
      check("rd s_ren", s_ren, 1'b1);
      check("rd s_raddr", s_raddr, 8'h08);
      check("rd gnt", gnt, 2'b10);
      nxt(); smp();
      check("rd s_ren pulse", s_ren, 1'b0);
      check("rd s_raddr held", s_raddr, 8'h08);
      check("rd no early rvalid", m1_rvalid, 1'b0);
      nxt(); smp();
      check("rd no early rvalid 2", m1_rvalid, 1'b0);
      nxt(); s_rvalid = 1'b1; s_rdata = 16'h0ABC; smp();
      check("rd m1_rvalid", m1_rvalid, 1'b1);
      check("rd m1_rdata", m1_rdata, 16'h0ABC);
      check("rd m0 quiet", {m0_rvalid, m0_rdata, m0_wready}, 18'h0);
      check("rd no timeout", timeout_err, 1'b0);
      nxt(); s_rvalid = 1'b0; m1_ren = 1'b0; smp();
      check("rd done gnt", gnt, 2'b00);
      check("rd done rvalid", {m1_rvalid, m1_rdata}, 17'h0);

      // Write before read on the same master
      nxt(); m1_wen = 1'b1; m1_waddr = 8'h40; m1_wdata = 16'h5555; m1_wstrb = 2'b01; m1_ren = 1'b1; m1_raddr = 8'h44;
      smp();
      nxt(); smp();
      check("wbr write first", {s_wen, s_ren, m1_wready}, 3'b101);
      check("wbr s_waddr", s_waddr, 8'h40);
      nxt(); m1_wen = 1'b0; smp();
      check("wbr idle gap", {gnt, s_ren}, 3'b000);
      nxt(); smp();
      check("wbr read issue", {gnt, s_ren}, 3'b101);
      check("wbr s_raddr", s_raddr, 8'h44);
      nxt(); s_rvalid = 1'b1; s_rdata = 16'h1234; smp();
      check("wbr read data", {m1_rvalid, m1_rdata}, {1'b1, 16'h1234});
      nxt(); s_rvalid = 1'b0; m1_ren = 1'b0; smp();

      // Read timeout on m0, slave never answers
      nxt(); m0_ren = 1'b1; m0_raddr = 8'h10; s_rdata = 16'hFFFF; smp();
      nxt(); smp();
      check("to s_ren", s_ren, 1'b1);
      early = 0;
      for (int i = 1; i < 256; i++) begin
         nxt(); smp();
         if (m0_rvalid || timeout_err || s_ren) early++;
      end
      check("to early pulses", early, 0);
      nxt(); smp();
      check("to m0_rvalid", m0_rvalid, 1'b1);
      check("to m0_rdata", m0_rdata, 16'h0000);
      check("to timeout_err", timeout_err, 1'b1);
      check("to m1 quiet", m1_rvalid, 1'b0);
      nxt(); m0_ren = 1'b0; smp();
      check("to back idle", {gnt, timeout_err, m0_rvalid}, 4'b0000);
      nxt(); m1_wen = 1'b1; m1_waddr = 8'h50; m1_wdata = 16'h0BEE; m1_wstrb = 2'b11; smp();
      nxt(); smp();
      check("to next write", {gnt, m1_wready, s_wen}, 4'b1011);
      check("to next s_waddr", s_waddr, 8'h50);
      nxt(); m1_wen = 1'b0; smp();

      // Slave stall, then m0 abort; stray s_rvalid must be ignored
      nxt(); s_wready = 1'b0; m0_wen = 1'b1; m0_waddr = 8'h60; s_rvalid = 1'b1; s_rdata = 16'h7777; smp();
      check("stray rvalid idle", {m0_rvalid, m1_rvalid}, 2'b00);
      nxt(); smp();
      check("stall s_wen", s_wen, 1'b1);
      check("stall no wready", m0_wready, 1'b0);
      check("stall gnt", gnt, 2'b01);
      check("stray rvalid wr", {m0_rvalid, m1_rvalid, m0_rdata}, 18'h0);
      nxt(); m0_wen = 1'b0; s_rvalid = 1'b0; smp();
      check("abort s_wen", {s_wen, m0_wready}, 2'b00);
      nxt(); s_wready = 1'b1; smp();
      check("abort idle gnt", gnt, 2'b00);
      nxt(); m0_wen = 1'b1; m0_waddr = 8'h20; m1_wen = 1'b1; m1_waddr = 8'h30; smp();
      nxt(); smp();
      check("abort keeps history", gnt, 2'b01);
      check("tie wready", {m1_wready, m0_wready}, 2'b01);
      nxt(); m0_wen = 1'b0; smp();
      nxt(); smp();
      check("tie second gnt", gnt, 2'b10);
      check("tie second wready", {m1_wready, m0_wready}, 2'b10);
      check("tie second s_waddr", s_waddr, 8'h30);
      nxt(); m1_wen = 1'b0; smp();

      // Contention: both masters hold wen from reset, 4 writes each
      nxt(); rst = 1'b1; m0_wen = 1'b1; m1_wen = 1'b1;
      nxt();
      nxt(); rst = 1'b0; smp();
      check("cont idle gnt", gnt, 2'b00);
      n0 = 0; n1 = 0;
      for (int k = 0; k < 8; k++) begin
         exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
         nxt(); smp();
         check($sformatf("cont gnt %0d", k), gnt, exp_g);
         check($sformatf("cont wready %0d", k), {m1_wready, m0_wready}, exp_g);
         if (m0_wready) n0++;
         if (m1_wready) n1++;
         nxt();
         if (n0 == 4) m0_wen = 1'b0;
         if (n1 == 4) m1_wen = 1'b0;
         smp();
         check($sformatf("cont idle %0d", k), gnt, 2'b00);
      end

      // Reset during RD_WAIT with a late s_rvalid
      nxt(); m0_ren = 1'b1; m0_raddr = 8'h70; smp();
      nxt(); smp();
      check("rr s_ren", s_ren, 1'b1);
      nxt(); smp();
      check("rr wait gnt", gnt, 2'b01);
      nxt(); rst = 1'b1; s_rvalid = 1'b1; s_rdata = 16'h4321; smp();
      check("rr reset cycle", {m0_rvalid, m1_rvalid, s_ren, timeout_err}, 4'b0000);
      nxt(); rst = 1'b0; m0_ren = 1'b0; smp();
      check("rr gnt", gnt, 2'b00);
      check("rr late rvalid", {m0_rvalid, m0_rdata}, 17'h0);
      nxt(); s_rvalid = 1'b0; smp();
      check("rr still idle", gnt, 2'b00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/lb_arbiter.md
Name: lb_arbiter

Overview:
Two-master local-bus arbiter that shares the single CSR map slave port between the SPI bridge (master 0) and an on-chip sequencer/debug master (master 1). It runs in the clk domain between the bus masters and the register map. It grants one whole transaction at a time using round-robin priority. It adds a read timeout so that a missing slave rvalid cannot hang either master.

Parameters:
ADDR_W, 8, local-bus address width
DATA_W, 16, local-bus data width
STRB_W, DATA_W/8, write-strobe width
TIMEOUT, 255, maximum cycles to wait for s_rvalid before aborting a read (1..65535)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
mN_waddr  in  ADDR_W  master N write address (N = 0, 1; same for all mN_ ports)
mN_wdata  in  DATA_W  master N write data
mN_wstrb  in  STRB_W  master N write strobes
mN_wen  in  1  master N write request; held until mN_wready
mN_wready  out  1  master N write accepted (1-cycle pulse)
mN_raddr  in  ADDR_W  master N read address
mN_ren  in  1  master N read request; held until mN_rvalid
mN_rdata  out  DATA_W  master N read data, valid with mN_rvalid
mN_rvalid  out  1  master N read response (1-cycle pulse)
s_waddr  out  ADDR_W  slave write address
s_wdata  out  DATA_W  slave write data
s_wstrb  out  STRB_W  slave write strobes
s_wen  out  1  slave write enable
s_wready  in  1  slave write ready
s_raddr  out  ADDR_W  slave read address
s_ren  out  1  slave read enable (1-cycle pulse)
s_rdata  in  DATA_W  slave read data
s_rvalid  in  1  slave read valid
gnt  out  2  one-hot current grant; 0 when idle
timeout_err  out  1  1-cycle pulse on read timeout

Behaviour:
- Reset values: state=IDLE, gnt=0, last=1 (so m0 wins first tie). All wready/rvalid/s_wen/s_ren/timeout_err=0. All rdata=0. Timeout counter=0.
- States: IDLE, WR, RD_ISSUE, RD_WAIT.
- Master N requests when mN_wen or mN_ren is high. If both are high on the same master, the write is served first.
- IDLE: with a single requester, grant it. With both requesting, grant the master other than last. The grant is registered, so the bus transaction starts 1 cycle after the request is seen.
- IDLE → WR if the granted master has wen; otherwise IDLE → RD_ISSUE.
- WR: s_waddr/s_wdata/s_wstrb are muxed from the granted master and s_wen=1. mN_wready = s_wready for the granted master only. On s_wen && s_wready: last←grant, → IDLE.
- RD_ISSUE: s_raddr is muxed from the granted master and s_ren=1 for exactly one cycle. The timeout counter clears. → RD_WAIT.
- RD_WAIT: s_raddr stays held and the counter increments each cycle.
  - On s_rvalid: granted mN_rvalid=1 and mN_rdata=s_rdata in the same cycle (combinational); last←grant, → IDLE.
  - If the counter reaches TIMEOUT without s_rvalid: granted mN_rvalid=1, mN_rdata=0, timeout_err=1; last←grant, → IDLE.
  - s_rvalid outside RD_WAIT is ignored.
- Abort: if the granted master drops its request in WR before wready, → IDLE with no grant-history update. A read, once issued, always completes or times out.
- The non-granted master always sees wready=0, rvalid=0 and rdata=0.
- s_* address/data outputs are 0 in IDLE.
- After each completed transaction, the FSM returns to IDLE for one cycle, so a master's back-to-back transactions are spaced by at least one cycle.
- Reset mid-transaction: immediate return to IDLE. No wready/rvalid pulse is emitted, and s_wen/s_ren drop in the reset cycle.
- Minimum latency:
  - Write: request at cycle 0 → s_wen at cycle 1 → wready at cycle 1 if the slave is ready.
  - Read: s_ren at cycle 1 → rvalid no earlier than cycle 2.

Test Plan:
- Single write: m0_wen, addr 0x04, data 0x0007, strb 2'b11, s_wready tied 1 → s_wen high in cycle 1 with matching fields; m0_wready pulses in cycle 1; gnt=2'b01 then 0.
- Single read: m1_ren, addr 0x08; slave returns rvalid 3 cycles after s_ren with 0x0ABC → s_ren is a 1-cycle pulse; m1_rvalid=1 with 0x0ABC in the same cycle; m0 outputs stay 0.
- Contention: m0 and m1 both hold wen from reset, each repeating 4 writes → grants alternate m0, m1, m0, m1…; no master is granted twice in a row while the other waits.
- Timeout: m0_ren with the slave never asserting rvalid, TIMEOUT=255 → m0_rvalid=1, m0_rdata=0 and timeout_err pulse 256 cycles after s_ren; the FSM returns to IDLE and a following m1 write succeeds.
- Write-before-read: m1_wen and m1_ren both high → write completes first, then the read is issued after an IDLE cycle.
- Reset mid-read: rst asserted during RD_WAIT → gnt=0, no rvalid; a late s_rvalid after reset is ignored.
